// File: rtl/regfile_sb.sv
// regfile_sb: two-write / two-read register file with a per-register
// pending (scoreboard) bit. Reservations mark a register pending; a write
// to that register clears it. Optional hardwired-zero r0 and write-to-read
// forwarding.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy0,
    output logic              busy1,
    output logic              rsv_hit
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic              we0_ok;
    logic              we1_ok;
    logic              rsv_ok;
    logic              rsv_hit_nxt;

    // Writes and reservations aimed at a hardwired-zero r0 are dropped here,
    // so nothing downstream ever touches r0's data or pending bit.
    assign we0_ok = we0 && !((ZERO_R0 != 0) && (waddr0 == ZERO_ADDR));
    assign we1_ok = we1 && !((ZERO_R0 != 0) && (waddr1 == ZERO_ADDR));
    assign rsv_ok = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == ZERO_ADDR));

    // Read value for one port: r0 zero, then port-1 forward, port-0 forward, storage.
    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = regs[a];
        if ((BYPASS != 0) && we0_ok && (waddr0 == a)) d = wdata0;
        if ((BYPASS != 0) && we1_ok && (waddr1 == a)) d = wdata1;
        if ((ZERO_R0 != 0) && (a == ZERO_ADDR))       d = '0;
        return d;
    endfunction

    // Busy for one port: pending bit, masked when a forwarded write covers it.
    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = pending[a];
        if ((BYPASS != 0) && ((we0_ok && (waddr0 == a)) || (we1_ok && (waddr1 == a)))) b = 1'b0;
        if ((ZERO_R0 != 0) && (a == ZERO_ADDR)) b = 1'b0;
        return b;
    endfunction

    // Combinational read ports.
    always_comb begin
        rdata0 = read_data(raddr0);
        rdata1 = read_data(raddr1);
        busy0  = read_busy(raddr0);
        busy1  = read_busy(raddr1);
    end

    // Next pending vector: writes clear first, then a reservation sets, so a
    // same-edge reservation wins over a write to the same register.
    always_comb begin
        // NOTE: start from a full default so every path assigns every bit; no latch.
        pending_nxt = pending;
        if (we0_ok) pending_nxt[waddr0] = 1'b0;
        if (we1_ok) pending_nxt[waddr1] = 1'b0;
        if (rsv_ok) pending_nxt[rsv_addr] = 1'b1;
    end

    // A hit is a reservation to a register already pending that no write at
    // this edge is clearing.
    assign rsv_hit_nxt = rsv_ok && pending[rsv_addr]
                         && !(we0_ok && (waddr0 == rsv_addr))
                         && !(we1_ok && (waddr1 == rsv_addr));

    // Register storage; port 1 is assigned last so it wins on an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset on purpose -- reads of never-written
            // registers must return 0 -- which keeps it in flops, not a RAM.
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            // NOTE: non-blocking; with two assignments to one element the later one takes effect.
            if (we0_ok) regs[waddr0] <= wdata0;
            if (we1_ok) regs[waddr1] <= wdata1;
        end
    end

    // Scoreboard state: pending bits and the one-cycle reservation-hit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            rsv_hit <= 1'b0;
        end else begin
            pending <= pending_nxt;
            rsv_hit <= rsv_hit_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven bench for regfile_sb. Each vector drives one
// cycle; its expected outputs go into a scoreboard queue and are popped and
// compared on the falling edge of that cycle, before the commit edge.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, rsv_en;
    logic [3:0]  waddr0, waddr1, raddr0, raddr1, rsv_addr;
    logic [15:0] wdata0, wdata1;
    logic [15:0] rdata0, rdata1;
    logic        busy0, busy1, rsv_hit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we0;  logic [3:0] wa0; logic [15:0] wd0;
        logic        we1;  logic [3:0] wa1; logic [15:0] wd1;
        logic [3:0]  ra0;  logic [3:0] ra1;
        logic        rsv;  logic [3:0] rsa;
        logic [15:0] e_rd0; logic [15:0] e_rd1;
        logic        e_b0;  logic e_b1;  logic e_hit;
    } vec_t;

    typedef struct {
        logic [15:0] rd0; logic [15:0] rd1;
        logic        b0;  logic b1;  logic hit;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy0(busy0), .busy1(busy1), .rsv_hit(rsv_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input int w0, input int a0, input int d0,
                                input int w1, input int a1, input int d1,
                                input int r0, input int r1, input int rv, input int ra,
                                input int erd0, input int erd1,
                                input int eb0, input int eb1, input int eh);
        vec_t v;
        v.we0 = 1'(w0);  v.wa0 = 4'(a0); v.wd0 = 16'(d0);
        v.we1 = 1'(w1);  v.wa1 = 4'(a1); v.wd1 = 16'(d1);
        v.ra0 = 4'(r0);  v.ra1 = 4'(r1);
        v.rsv = 1'(rv);  v.rsa = 4'(ra);
        v.e_rd0 = 16'(erd0); v.e_rd1 = 16'(erd1);
        v.e_b0 = 1'(eb0); v.e_b1 = 1'(eb1); v.e_hit = 1'(eh);
        return v;
    endfunction

    task automatic drive_idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    // One cycle: drive after the rising edge, pop and compare on the falling edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
        we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
        raddr0 = v.ra0; raddr1 = v.ra1;
        rsv_en = v.rsv; rsv_addr = v.rsa;
        sb.push_back('{rd0: v.e_rd0, rd1: v.e_rd1, b0: v.e_b0, b1: v.e_b1, hit: v.e_hit});
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", idx, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("rdata0", idx, 32'(rdata0), 32'(e.rd0));
            check("rdata1", idx, 32'(rdata1), 32'(e.rd1));
            check("busy0", idx, 32'(busy0), 32'(e.b0));
            check("busy1", idx, 32'(busy1), 32'(e.b1));
            check("rsv_hit", idx, 32'(rsv_hit), 32'(e.hit));
        end
    endtask

    initial begin
        // Columns: we0 wa0 wd0 | we1 wa1 wd1 | ra0 ra1 | rsv rsa | rd0 rd1 b0 b1 hit
        vecs.push_back(mk(1, 3, 'hA5A5, 0, 0, 0,      3, 3,  0, 0,  'hA5A5, 'hA5A5, 0, 0, 0)); // 0 fwd port0
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      3, 0,  0, 0,  'hA5A5, 0,      0, 0, 0)); // 1 stored
        vecs.push_back(mk(1, 5, 'h1111, 1, 5, 'h2222, 5, 5,  0, 0,  'h2222, 'h2222, 0, 0, 0)); // 2 clash fwd
        vecs.push_back(mk(1, 0, 'hFFFF, 0, 0, 0,      0, 5,  0, 0,  0,      'h2222, 0, 0, 0)); // 3 r0 write
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 5,  0, 0,  0,      'h2222, 0, 0, 0)); // 4 r0 stays 0
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      7, 7,  1, 7,  0,      0,      0, 0, 0)); // 5 reserve 7
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      3, 7,  1, 7,  'hA5A5, 0,      0, 1, 0)); // 6 reserve 7 again
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      7, 7,  0, 0,  0,      0,      1, 1, 1)); // 7 hit pulse
        vecs.push_back(mk(0, 0, 0,      1, 7, 'hBEEF, 7, 7,  0, 0,  'hBEEF, 'hBEEF, 0, 0, 0)); // 8 write clears
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      7, 7,  0, 0,  'hBEEF, 'hBEEF, 0, 0, 0)); // 9 cleared
        vecs.push_back(mk(1, 9, 'h1234, 0, 0, 0,      9, 9,  1, 9,  'h1234, 'h1234, 0, 0, 0)); // 10 rsv+write
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      9, 9,  0, 0,  'h1234, 'h1234, 1, 1, 0)); // 11 rsv wins
        vecs.push_back(mk(0, 0, 0,      1, 9, 'h5678, 9, 3,  1, 9,  'h5678, 'hA5A5, 0, 0, 0)); // 12 pending+write
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      9, 7,  0, 0,  'h5678, 'hBEEF, 1, 0, 0)); // 13 no hit
        vecs.push_back(mk(1, 2, 'h00C3, 1, 4, 'h3C00, 2, 4,  1, 0,  'h00C3, 'h3C00, 0, 0, 0)); // 14 rsv r0
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 2,  1, 0,  0,      'h00C3, 0, 0, 0)); // 15 r0 again
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 4,  0, 0,  0,      'h3C00, 0, 0, 0)); // 16 no hit r0
        vecs.push_back(mk(1,10, 'h0A0A, 1,11, 'h0B0B,11,10,  0, 0,  'h0B0B, 'h0A0A, 0, 0, 0)); // 17 two fwds
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,     15,10,  1,15,  0,      'h0A0A, 0, 0, 0)); // 18 reserve 15
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,     15,10,  0, 0,  0,      'h0A0A, 1, 0, 0)); // 19 top addr
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,     15, 9,  1,15,  0,      'h5678, 1, 1, 0)); // 20 re-reserve 15

        // Reset with idle inputs; outputs must be zero without any clock edge.
        rst_n = 1'b0;
        drive_idle();
        raddr0 = 4'd3; raddr1 = 4'd15;
        #1;
        check("rst_rsv_hit", 0, 32'(rsv_hit), 32'd0);
        check("rst_rdata0", 0, 32'(rdata0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Every address reads zero and not busy after reset.
        for (int a = 0; a < 16; a++)
            apply(mk(0, 0, 0, 0, 0, 0, a, 15 - a, 0, 0, 0, 0, 0, 0, 0), 100 + a);

        foreach (vecs[i]) apply(vecs[i], i);

        // Mid-sequence asynchronous reset: hit flag, pending and data all drop at once.
        @(posedge clk);
        #1;
        drive_idle();
        raddr0 = 4'd9; raddr1 = 4'd15;
        #1;
        check("pre_rst_hit", 0, 32'(rsv_hit), 32'd1);
        check("pre_rst_rdata0", 0, 32'(rdata0), 32'h5678);
        check("pre_rst_busy1", 0, 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rdata0", 0, 32'(rdata0), 32'd0);
        check("async_rdata1", 0, 32'(rdata1), 32'd0);
        check("async_busy0", 0, 32'(busy0), 32'd0);
        check("async_busy1", 0, 32'(busy1), 32'd0);
        check("async_rsv_hit", 0, 32'(rsv_hit), 32'd0);

        // Write and reservation held across an edge during reset are discarded.
        we0 = 1'b1; waddr0 = 4'd3; wdata0 = 16'h7777;
        rsv_en = 1'b1; rsv_addr = 4'd3;
        raddr0 = 4'd3;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        #1;
        check("rst_discard_rdata0", 0, 32'(rdata0), 32'd0);
        check("rst_discard_busy0", 0, 32'(busy0), 32'd0);
        check("rst_discard_hit", 0, 32'(rsv_hit), 32'd0);

        // First edge after release commits.
        apply(mk(1, 3, 'h7777, 0, 0, 0, 3, 9, 0, 0, 'h7777, 0, 0, 0, 0), 200);
        apply(mk(0, 0, 0,      0, 0, 0, 3, 9, 0, 0, 'h7777, 0, 0, 0, 0), 201);

        if (sb.size() != 0) check("sb_leftover", 0, 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, 16, register data width in bits, SHALL be legal for any value >= 1.
REQ-002 Parameter ADDR_W, 4, register address width, SHALL set the register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_R0, 1, when 1, register 0 SHALL be hardwired to zero and never reservable.
REQ-004 Parameter BYPASS, 1, when 1, same-cycle write data SHALL be forwarded to the read ports.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 we0/we1  input  1 each  write enables for write ports 0 and 1.
REQ-008 waddr0/waddr1  input  ADDR_W each  write addresses.
REQ-009 wdata0/wdata1  input  DATA_W each  write data.
REQ-010 raddr0/raddr1  input  ADDR_W each  read addresses.
REQ-011 rdata0/rdata1  output  DATA_W each  read data, combinational.
REQ-012 rsv_en  input  1  reserve request: marks register rsv_addr pending.
REQ-013 rsv_addr  input  ADDR_W  register to reserve.
REQ-014 busy0/busy1  output  1 each  pending status of raddr0/raddr1, combinational.
REQ-015 rsv_hit  output  1  registered flag: 1 for one cycle after a reservation is made to an already-pending register.

Function
REQ-016 Writes SHALL commit on the rising clk edge where the enable is high; a read in the following cycle SHALL return the new value.
REQ-017 If we0 and we1 target the same address in one cycle, port 1 data SHALL be stored.
REQ-018 With ZERO_R0=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 regardless of bypass.
REQ-019 With BYPASS=1, a read address matching an active write address in the same cycle SHALL return that write data, with port 1 taking priority over port 0; with BYPASS=0, reads SHALL return stored contents only.
REQ-020 Each register SHALL have a pending bit; rsv_en at a rising edge SHALL set pending[rsv_addr], except address 0 when ZERO_R0=1.
REQ-021 A commit on either write port SHALL clear pending[waddr] at the same edge.
REQ-022 If a reservation and a write hit the same register at the same edge, the register data SHALL update and the pending bit SHALL remain set (the reservation wins).
REQ-023 busyN SHALL equal pending[raddrN], forced to 0 when BYPASS=1 and an active write targets raddrN in the same cycle, and forced to 0 for address 0 when ZERO_R0=1.
REQ-024 rsv_hit SHALL assert for exactly one cycle after an rsv_en edge whose target was already pending and not cleared by a write at that edge; otherwise it SHALL be 0.
REQ-025 Out-of-range behaviour SHALL NOT exist: all 2**ADDR_W addresses are valid, and no wrap or masking is applied.

Reset
REQ-026 While rst_n=0, all registers SHALL be 0, all pending bits SHALL be 0, and rsv_hit SHALL be 0, taking effect immediately without a clock edge.
REQ-027 An rst_n assertion coincident with a write or reservation SHALL discard it; the first commit after release SHALL occur at the first rising edge with rst_n=1.
REQ-028 After reset, rdata0/rdata1 SHALL read 0 and busy0/busy1 SHALL be 0 for every address.

Verification
REQ-029 Reset, then read all 16 addresses -> rdata=0x0000 and busy=0 for each.
REQ-030 Set we0=1, waddr0=3, wdata0=0xA5A5 with raddr0=3 in the same cycle -> rdata0=0xA5A5 combinationally (BYPASS=1); next cycle with we0=0 -> rdata0=0xA5A5.
REQ-031 Set we0/we1 both to address 5 with data 0x1111/0x2222 -> register 5 = 0x2222; a write of 0xFFFF to address 0 -> rdata0=0 for raddr0=0.
REQ-032 Reserve address 7, then read raddr1=7 -> busy1=1; reserve 7 again -> rsv_hit=1 for one cycle; write 7 via we1 -> busy1=0 in the write cycle and after it.
REQ-033 Reserve and write address 9 at the same edge -> data is updated and busy stays 1; assert rst_n=0 mid-sequence -> all busy=0 and data=0 immediately.
